// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer: FSM states, BCD limits,
// the packed mm:ss time word and the preset clamp helper.
package countdown_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX      = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Count held as four BCD digits, minutes tens down to seconds ones.
  typedef struct packed {
    logic [DIGIT_W-1:0] m10;
    logic [DIGIT_W-1:0] m1;
    logic [DIGIT_W-1:0] s10;
    logic [DIGIT_W-1:0] s1;
  } bcd_time_t;

  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d,
                                                     input logic [DIGIT_W-1:0] lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/countdown_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_HZ enabled cycles.
// Holds its phase while disabled so a paused countdown resumes mid-second.
module countdown_prescaler #(
  parameter int CLK_HZ = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  // Next phase: clear wins, otherwise advance and wrap while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  // Phase register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/countdown_timer.sv
// mm:ss BCD countdown timer with load/start/pause strobes and a one-cycle
// ring pulse on expiry. Define COUNTDOWN_AUTO_RELOAD_EN to make expiry
// reload the last accepted preset and keep running instead of stopping.
module countdown_timer #(
  parameter int CLK_HZ = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       ring
);
  import countdown_pkg::*;

  state_e    state_q;
  bcd_time_t cnt_q, cnt_dec, preset_c;
  logic      running_q, ring_q;
  logic      load_ok, start_ok, cnt_zero, tick, expire, psc_clr;

  // One second off the count with BCD borrows; saturates at 00:00.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t != '0) begin
      if (t.s1 != '0) r.s1 = t.s1 - 4'd1;
      else begin
        r.s1 = BCD_MAX;
        if (t.s10 != '0) r.s10 = t.s10 - 4'd1;
        else begin
          r.s10 = SEC_TENS_MAX;
          if (t.m1 != '0) r.m1 = t.m1 - 4'd1;
          else begin
            r.m1  = BCD_MAX;
            r.m10 = t.m10 - 4'd1;
          end
        end
      end
    end
    return r;
  endfunction

  // Preset sanitising, strobe qualification and the decremented count.
  always_comb begin
    preset_c.m10 = clamp_digit(preset_min[7:4], BCD_MAX);
    preset_c.m1  = clamp_digit(preset_min[3:0], BCD_MAX);
    preset_c.s10 = clamp_digit(preset_sec[7:4], SEC_TENS_MAX);
    preset_c.s1  = clamp_digit(preset_sec[3:0], BCD_MAX);
    cnt_dec  = bcd_dec(cnt_q);
    cnt_zero = (cnt_q == '0);
    load_ok  = load && (state_q != ST_RUN);
    start_ok = start && !pause && !load;
    expire   = tick && !cnt_zero && (cnt_dec == '0);
    psc_clr  = load_ok || ((state_q == ST_IDLE) && start_ok && !cnt_zero);
  end

  countdown_prescaler #(.CLK_HZ(CLK_HZ)) u_psc (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state_q == ST_RUN),
    .clr     (psc_clr),
    .tick    (tick)
  );

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  bcd_time_t shadow_q;

  // Last accepted preset, replayed into the count on expiry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     shadow_q <= '0;
    else if (load_ok) shadow_q <= preset_c;
  end
`endif

  // Control FSM with registered count, running and ring outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      running_q <= 1'b0;
      ring_q    <= 1'b0;
    end else begin
      ring_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load_ok) cnt_q <= preset_c;
          else if (start_ok && !cnt_zero) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (tick)   cnt_q  <= cnt_dec;
          if (expire) ring_q <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          if (expire && (shadow_q != '0)) begin
            cnt_q <= shadow_q;
            if (pause) begin
              state_q   <= ST_PAUSE;
              running_q <= 1'b0;
            end
          end else
`endif
          if (expire) begin
            state_q   <= ST_DONE;
            running_q <= 1'b0;
          end else if (pause) begin
            state_q   <= ST_PAUSE;
            running_q <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (load_ok) begin
            cnt_q   <= preset_c;
            state_q <= ST_IDLE;
          end else if (start_ok) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (load_ok) begin
            cnt_q   <= preset_c;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign min_bcd = {cnt_q.m10, cnt_q.m1};
  assign sec_bcd = {cnt_q.s10, cnt_q.s1};
  assign running = running_q;
  assign ring    = ring_q;

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 1000, giving clk cycles per countdown second.
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock, 1 kHz nominal.
REQ-003 The block SHALL have port reset_n, input, 1 bit, the asynchronous active-low reset.
REQ-004 The block SHALL have port load, input, 1 bit, a one-cycle strobe that captures the preset.
REQ-005 The block SHALL have port preset_min, input, 8 bits, the preset minutes as BCD {tens, ones}, range 00-99.
REQ-006 The block SHALL have port preset_sec, input, 8 bits, the preset seconds as BCD {tens, ones}, range 00-59.
REQ-007 The block SHALL have port start, input, 1 bit, a one-cycle strobe that starts or resumes the countdown.
REQ-008 The block SHALL have port pause, input, 1 bit, a one-cycle strobe that halts the countdown.
REQ-009 The block SHALL have port min_bcd, output, 8 bits, the current minutes as BCD.
REQ-010 The block SHALL have port sec_bcd, output, 8 bits, the current seconds as BCD.
REQ-011 The block SHALL have port running, output, 1 bit, high while the state is RUN.
REQ-012 The block SHALL have port ring, output, 1 bit, a one-cycle expiry pulse that drives the downstream countdown_led ring input.

Function
REQ-013 The block SHALL implement states IDLE, RUN, PAUSE and DONE, and all outputs SHALL be registered.
REQ-014 The following transitions SHALL apply:
- IDLE to RUN on start when the count is non-zero.
- RUN to PAUSE on pause.
- PAUSE to RUN on start.
- RUN to DONE on expiry.
- DONE to IDLE on load.
REQ-015 A start strobe SHALL be ignored when the count is 00:00.
REQ-016 Load SHALL be accepted in IDLE, PAUSE and DONE, SHALL set the count to the preset on the next edge and SHALL move to IDLE.
REQ-017 Load SHALL be ignored in RUN.
REQ-018 On load, any BCD digit greater than 9 SHALL be clamped to 9, and a seconds tens digit greater than 5 SHALL be clamped to 5.
REQ-019 The block SHALL contain a prescaler that counts 0..CLK_HZ-1 in RUN only and emits a one-cycle tick at CLK_HZ-1.
REQ-020 The prescaler SHALL hold its value in PAUSE.
REQ-021 The prescaler SHALL clear on an IDLE-to-RUN transition and on load.
REQ-022 Each tick SHALL decrement the count by one second using BCD borrow rules:
- seconds ones 0 becomes 9 with a borrow to seconds tens;
- seconds tens 0 becomes 5 with a borrow to minutes;
- minutes follow the same ones/tens borrow rule.
REQ-023 The first tick after start SHALL occur exactly CLK_HZ cycles after the start edge.
REQ-024 The tick that moves the count from 00:01 to 00:00 SHALL assert ring for exactly one cycle, in the same cycle that the count reads 00:00, and SHALL enter DONE.
REQ-025 When load and start are asserted in the same cycle, load SHALL win and start SHALL be ignored.
REQ-026 When start and pause are asserted in the same cycle, pause SHALL win.
REQ-027 The count SHALL never wrap below 00:00.

Reset
REQ-028 On reset_n low, asynchronously:
- state SHALL be IDLE;
- count SHALL be 00:00;
- the prescaler SHALL be 0;
- running and ring SHALL be 0.
REQ-029 Reset asserted mid-countdown SHALL abort the countdown with no ring pulse.
REQ-030 After reset_n deasserts, the block SHALL remain in IDLE until a load followed by a start.

Configuration
REQ-031 With macro COUNTDOWN_AUTO_RELOAD_EN defined, expiry SHALL pulse ring, reload the last accepted preset on the same edge and remain in RUN, so min_bcd and sec_bcd show the preset, not 00:00.
REQ-032 With COUNTDOWN_AUTO_RELOAD_EN defined, expiry with a preset of 00:00 SHALL go to DONE.
REQ-033 Without COUNTDOWN_AUTO_RELOAD_EN, expiry SHALL enter DONE as in REQ-024, and no preset shadow register SHALL be built.

Structure
REQ-034 The state encodings, BCD constants (9, 5) and clamp widths SHALL reside in shared header countdown_pkg.
REQ-035 The prescaler SHALL be a separate sub-module named countdown_prescaler, with ports clk, reset_n, en, clr and tick.
REQ-036 BCD borrow and decrement logic SHALL remain inside countdown_timer.

Verification
REQ-037 Scenario 1: CLK_HZ=10, load 00:03, start -> ticks at cycles +10, +20 and +30 after start; ring is high for 1 cycle at +30 with the count at 00:00; the state ends in DONE.
REQ-038 Scenario 2: load 01:00, start, 1 tick -> the count reads 00:59 (borrow across minutes).
REQ-039 Scenario 3: load 00:05, start, pause after 15 cycles, wait 50 cycles, start -> the count stays at 00:04 during the pause, and the next tick comes 5 cycles after resume.
REQ-040 Scenario 4: load 7A:6F -> the count reads 79:59; a start at 00:00 is ignored and running stays 0.
REQ-041 Scenario 5: reset_n low at 00:01 mid-run -> all outputs are 0 immediately and no ring pulse occurs.
REQ-042 Scenario 6 (COUNTDOWN_AUTO_RELOAD_EN defined): load 00:02, start -> ring pulses at +20 and +40, the count reloads to 00:02 each time and running stays 1.
